// File: rtl/mips_interrupt_ctrl.sv
// mips_interrupt_ctrl: synchronises, edge-detects, masks and arbitrates interrupt lines for the MIPS core.
// Revision 1.0 - initial release.
`default_nettype none

module mips_interrupt_ctrl #(
  parameter int          N_SRC       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0080,
  parameter int          ID_W        = $clog2(N_SRC)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_SRC-1:0]  i_irq,
  input  logic              i_mask_we,
  input  logic [N_SRC-1:0]  i_mask_wdata,
  input  logic [31:0]       i_pc,
  input  logic              i_ack,
  input  logic              i_eret,
  output logic              o_irq_req,
  output logic [31:0]       o_irq_vector,
  output logic [ID_W-1:0]   o_cause,
  output logic [31:0]       o_epc,
  output logic [N_SRC-1:0]  o_pending,
  output logic [N_SRC-1:0]  o_mask,
  output logic              o_in_service
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [N_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [N_SRC-1:0]  irq_prev;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  clear_mask;

  logic              win_valid;
  logic [ID_W-1:0]   win_id;

  logic              req_nxt;
  logic [ID_W-1:0]   cause_nxt;
  logic [31:0]       vector_nxt;
  logic [31:0]       epc_nxt;
  logic              insvc_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      irq_prev <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      irq_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~irq_prev;
  assign eligible = pending & mask;

  // A new edge in the same cycle as an ack clear keeps the bit pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | rise;
      if (i_mask_we) begin
        mask <= i_mask_wdata;
      end
    end
  end

  // Descending scan so the lowest eligible index is the final assignment.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = o_irq_req;
    cause_nxt  = o_cause;
    vector_nxt = o_irq_vector;
    epc_nxt    = o_epc;
    insvc_nxt  = o_in_service;
    clear_mask = '0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nxt  = ST_REQ;
          req_nxt    = 1'b1;
          cause_nxt  = win_id;
          vector_nxt = VECTOR_BASE + ({{(32-ID_W){1'b0}}, win_id} << 3);
        end
      end
      ST_REQ: begin
        if (i_ack) begin
          state_nxt           = ST_SERVICE;
          req_nxt             = 1'b0;
          insvc_nxt           = 1'b1;
          epc_nxt             = i_pc;
          clear_mask[o_cause] = 1'b1;
        end else if (!mask[o_cause]) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (i_eret) begin
          state_nxt = ST_IDLE;
          insvc_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
        insvc_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      o_irq_req    <= 1'b0;
      o_cause      <= '0;
      o_irq_vector <= VECTOR_BASE;
      o_epc        <= '0;
      o_in_service <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_irq_req    <= req_nxt;
      o_cause      <= cause_nxt;
      o_irq_vector <= vector_nxt;
      o_epc        <= epc_nxt;
      o_in_service <= insvc_nxt;
    end
  end

  assign o_pending = pending;
  assign o_mask    = mask;

endmodule

`default_nettype wire

// File: tb/tb_mips_interrupt_ctrl.sv
// tb_mips_interrupt_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_mips_interrupt_ctrl;

  localparam int          S  = 2;
  localparam logic [31:0] VB = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] pc;
  logic        ack;
  logic        eret;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [1:0]  cause;
  logic [31:0] epc;
  logic [3:0]  pending;
  logic [3:0]  mask;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;

  mips_interrupt_ctrl #(
    .N_SRC(4), .SYNC_STAGES(S), .VECTOR_BASE(VB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_mask_we(mask_we),
    .i_mask_wdata(mask_wdata), .i_pc(pc), .i_ack(ack), .i_eret(eret),
    .o_irq_req(irq_req), .o_irq_vector(irq_vector), .o_cause(cause),
    .o_epc(epc), .o_pending(pending), .o_mask(mask), .o_in_service(in_service)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = requesting, 2 = in service.
  logic [3:0]  m_pend, m_mask, m_hist[$];
  logic        m_req, m_insvc;
  logic [1:0]  m_cause;
  logic [31:0] m_vec, m_epc;
  int          m_mode;

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_req = 0; m_insvc = 0; m_cause = 0;
    m_vec = VB; m_epc = 0; m_mode = 0;
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back(4'b0);
  endtask

  task automatic m_step();
    logic [3:0] rise, clr, old_mask, elig;
    int w;
    clr = 0; old_mask = m_mask; elig = m_pend & old_mask;
    rise = m_hist[S-1] & ~m_hist[S];
    m_hist.push_front(irq);
    void'(m_hist.pop_back());
    case (m_mode)
      0: if (elig != 0) begin
        w = 0;
        for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
        m_cause = 2'(w); m_vec = VB + 32'(w) * 8; m_req = 1; m_mode = 1;
      end
      1: if (ack) begin
        m_epc = pc; clr[m_cause] = 1'b1; m_req = 0; m_insvc = 1; m_mode = 2;
      end else if (!old_mask[m_cause]) begin
        m_req = 0; m_mode = 0;
      end
      default: if (eret) begin
        m_insvc = 0; m_mode = 0;
      end
    endcase
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_wdata;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0; irq = 0; mask_we = 0; mask_wdata = 0; pc = 0; ack = 0; eret = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1; mask_wdata = m;
    step();
    mask_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; irq = 4'hF; mask_we = 0; mask_wdata = 0; pc = 0; ack = 0; eret = 0;
    step(); step(); step();
    n_checks++; if (irq_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %b want 0", irq_req); end
    n_checks++; if (pending !== 4'h0)   begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_checks++; if (mask !== 4'h0)      begin n_fail++; $display("FAIL reset_mask: got %h want 0", mask); end
    n_checks++; if (epc !== 32'h0)      begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_checks++; if (cause !== 2'd0)     begin n_fail++; $display("FAIL reset_cause: got %0d want 0", cause); end
    n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_insvc: got %b want 0", in_service); end
    n_checks++; if (irq_vector !== VB)  begin n_fail++; $display("FAIL reset_vector: got %h want %h", irq_vector, VB); end
    rst_n = 1;
    step();
    n_checks++; if (pending !== 4'h0) begin n_fail++; $display("FAIL reset_release_pending: got %h want 0", pending); end
    step(); step();
    n_checks++; if (pending !== m_pend) begin n_fail++; $display("FAIL reset_release_edges: got %h want %h", pending, m_pend); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_req: got %b want 0", irq_req); end
  endtask

  task automatic test_single();
    do_reset();
    set_mask(4'b0001);
    irq = 4'b0001; step(); irq = 0;
    step(); step();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", irq_req); end
    step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", irq_req); end
    n_checks++; if (cause !== 2'd0) begin n_fail++; $display("FAIL single_cause: got %0d want 0", cause); end
    n_checks++; if (irq_vector !== 32'h80) begin n_fail++; $display("FAIL single_vector: got %h want 80", irq_vector); end
    pc = 32'h40; ack = 1; step(); ack = 0;
    n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL single_epc: got %h want 40", epc); end
    n_checks++; if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL single_pend_clr: got %b want 0", pending[0]); end
    n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL single_insvc: got %b want 1", in_service); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", irq_req); end
    eret = 1; step(); eret = 0;
    n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL single_eret: got %b want 0", in_service); end
  endtask

  task automatic test_priority();
    do_reset();
    set_mask(4'hF);
    irq = 4'b1010; step(); irq = 0;
    step(); step(); step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b want 1", irq_req); end
    n_checks++; if (cause !== 2'd1) begin n_fail++; $display("FAIL prio_cause1: got %0d want 1", cause); end
    n_checks++; if (irq_vector !== 32'h88) begin n_fail++; $display("FAIL prio_vector1: got %h want 88", irq_vector); end
    ack = 1; step(); ack = 0;
    eret = 1; step(); eret = 0;
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %b want 0", irq_req); end
    step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL prio_req2: got %b want 1", irq_req); end
    n_checks++; if (cause !== 2'd3) begin n_fail++; $display("FAIL prio_cause3: got %0d want 3", cause); end
    n_checks++; if (irq_vector !== 32'h98) begin n_fail++; $display("FAIL prio_vector3: got %h want 98", irq_vector); end
  endtask

  task automatic test_masking();
    do_reset();
    irq = 4'b0100; step(); irq = 0;
    step(); step(); step();
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL mask_pending: got %b want 0100", pending); end
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_noreq: got %b want 0", irq_req); end
    set_mask(4'b0100);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_old_used: got %b want 0", irq_req); end
    step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL mask_req: got %b want 1", irq_req); end
    n_checks++; if (cause !== 2'd2) begin n_fail++; $display("FAIL mask_cause: got %0d want 2", cause); end
    set_mask(4'b0000);
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL mask_hold: got %b want 1", irq_req); end
    step();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_withdraw: got %b want 0", irq_req); end
    n_checks++; if (pending[2] !== 1'b1) begin n_fail++; $display("FAIL mask_keep_pend: got %b want 1", pending[2]); end
  endtask

  task automatic test_retrigger();
    do_reset();
    set_mask(4'hF);
    irq = 4'b0001; step(); irq = 0;
    step(); step(); step();
    ack = 1; pc = 32'h100; step(); ack = 0;
    irq = 4'b0001; step(); irq = 0;
    repeat (4) step();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL retrig_nonest: got %b want 0", irq_req); end
    n_checks++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL retrig_pend: got %b want 1", pending[0]); end
    eret = 1; step(); eret = 0;
    step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL retrig_after_eret: got %b want 1", irq_req); end
    irq = 4'b0001; step(); irq = 0;
    step();
    ack = 1; pc = 32'h200; step(); ack = 0;
    n_checks++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL retrig_set_wins: got %b want 1", pending[0]); end
    n_checks++; if (epc !== 32'h200) begin n_fail++; $display("FAIL retrig_epc: got %h want 200", epc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mask(4'hF);
    irq = 4'b0010; step(); irq = 0;
    step(); step(); step();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL async_pre_req: got %b want 1", irq_req); end
    #1 rst_n = 0;
    #1;
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b want 0", irq_req); end
    n_checks++; if (pending !== 4'h0 || mask !== 4'h0) begin n_fail++; $display("FAIL async_state: got pend %h mask %h want 0 0", pending, mask); end
    n_checks++; if (cause !== 2'd0 || irq_vector !== VB) begin n_fail++; $display("FAIL async_cause_vec: got %0d %h want 0 %h", cause, irq_vector, VB); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 4'($urandom);
      ack        = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 3) == 0);
      pc         = $urandom;
      step();
      n_checks++;
      if ({irq_req, cause, irq_vector, epc, pending, mask, in_service} !==
          {m_req, m_cause, m_vec, m_epc, m_pend, m_mask, m_insvc}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got req=%b cause=%0d vec=%h epc=%h pend=%h mask=%h insvc=%b want req=%b cause=%0d vec=%h epc=%h pend=%h mask=%h insvc=%b",
                 c, irq_req, cause, irq_vector, epc, pending, mask, in_service,
                 m_req, m_cause, m_vec, m_epc, m_pend, m_mask, m_insvc);
      end
    end
    ack = 0; eret = 0; mask_we = 0; irq = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_retrigger();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_interrupt_ctrl.md
Name: mips_interrupt_ctrl

Overview:
Interrupt controller for the unpipelined MIPS core.
- Synchronises N_SRC asynchronous interrupt lines (bit 0 is the core's i_external_interrupt) and edge-detects them into pending bits.
- Masks and priority-arbitrates the pending bits, then requests the core with a vector and cause.
- On acknowledge, captures EPC and holds an in-service state until the core executes ERET.

Parameters:
N_SRC, 4, number of interrupt sources; power of 2, >= 2
SYNC_STAGES, 2, synchroniser flops per source; >= 2
VECTOR_BASE, 32'h0000_0080, handler address for source 0
ID_W, $clog2(N_SRC), width of cause id (derived, not overridden)

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_irq  in  N_SRC  asynchronous interrupt lines, rising-edge sensitive; bit 0 = external interrupt
i_mask_we  in  1  mask register write strobe
i_mask_wdata  in  N_SRC  new mask value (1 = enabled)
i_pc  in  32  PC of the next instruction to execute, sampled on acknowledge
i_ack  in  1  core takes the interrupt at an instruction boundary
i_eret  in  1  core executes ERET
o_irq_req  out  1  interrupt request to core
o_irq_vector  out  32  handler address for the latched source
o_cause  out  ID_W  id of the latched source
o_epc  out  32  captured return PC
o_pending  out  N_SRC  pending bits
o_mask  out  N_SRC  mask register
o_in_service  out  1  handler active

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous active-low on i_rst_n.
- Reset values: every flop clears, including synchronisers and edge-history. Outputs: o_irq_req=0, o_pending=0, o_mask=0, o_epc=0, o_cause=0, o_in_service=0, o_irq_vector=VECTOR_BASE. FSM = IDLE.
- Reset mid-operation: aborts any request or service immediately. Pending edges are lost.
- Synchronisers: SYNC_STAGES-flop chain per bit. A synchronised 0->1 transition sets pending[i] on the next edge. Level-high lines do not re-trigger.
- Mask: i_mask_we loads o_mask on the next edge. Masked bits still accumulate pending; they are only excluded from arbitration.
- Arbitration: eligible = pending & mask. Lowest index wins.
- FSM, IDLE:
  - If eligible != 0: latch the winning id into o_cause, set o_irq_vector = VECTOR_BASE + (id << 3), go to REQ, and assert o_irq_req in the same update (registered).
  - Latency from an i_irq rising edge to o_irq_req=1: SYNC_STAGES+2 cycles, mask already enabled.
- FSM, REQ:
  - o_irq_req held at 1. o_cause and o_irq_vector are frozen; a higher-priority arrival does not preempt.
  - i_ack=1: o_epc <= i_pc, pending[o_cause] cleared, o_irq_req <= 0, o_in_service <= 1, go to SERVICE.
  - If mask[o_cause] is 0 and i_ack=0: withdraw, o_irq_req <= 0, go to IDLE.
  - i_ack in the same cycle as mask removal: the ack wins.
- FSM, SERVICE:
  - No nesting. o_irq_req stays 0; new edges still set pending.
  - i_eret=1: o_in_service <= 0, go to IDLE. Arbitration resumes the following cycle.
- Ignored inputs: i_ack outside REQ; i_eret outside SERVICE.
- Simultaneous new edge on source k and clear of pending[k] (ack cycle): set wins, so pending[k] stays 1.
- Mask write and arbitration in the same cycle: arbitration uses the old mask.
- o_epc holds its value until the next ack.

Test Plan:
- Reset: hold i_rst_n=0 with i_irq=4'hF, then release. All outputs stay at reset values, o_irq_vector=32'h80. Edges arriving only from the release onward set pending.
- Single source: mask=4'b0001, pulse i_irq[0]. o_irq_req=1 exactly 4 cycles after the edge, o_cause=0, vector=32'h80. Ack with i_pc=32'h0000_0040: o_epc=32'h40, pending[0]=0, o_in_service=1. i_eret: o_in_service=0.
- Priority: mask=4'hF, edges on bits 3 and 1 in the same cycle. Request has o_cause=1, vector=32'h88. After ack+eret, a second request has o_cause=3, vector=32'h98.
- Masking: mask=0, pulse i_irq[2]. pending=4'b0100 and no request. Write mask=4'b0100: o_irq_req rises 2 cycles after the write strobe, o_cause=2. Clear the mask before ack: request withdrawn next cycle, pending[2] still 1.
- Re-trigger and no nesting: during SERVICE, pulse i_irq[0]. No request appears until eret, then a request follows. An edge on the granted source in the ack cycle leaves its pending bit set.
- Async reset mid-REQ: assert i_rst_n low between clock edges while o_irq_req=1. The request drops without a clock edge; all state clears.
